// File: rtl/track_if.sv
// track_if: sensor/run/obstacle inputs and ctr/state outputs of track_ctrl; master drives inputs, slave is the controller
interface track_if;
    logic [2:0] sensor;
    logic       run_en;
    logic       obstacle;
    logic [2:0] ctr;
    logic [2:0] state;
    modport master (output sensor, run_en, obstacle, input ctr, state);
    modport slave  (input sensor, run_en, obstacle, output ctr, state);
endinterface

// File: rtl/track_ctrl.sv
// track_ctrl: line-tracking drive controller; ports clk, rst, bus (sensor/run_en/obstacle in, ctr/state out, registered)
module track_ctrl #(
    parameter int unsigned DEB_CYCLES   = 50000,
    parameter int unsigned BOOST_CYCLES = 2500000,
    parameter int unsigned LOST_CYCLES  = 5000000,
    parameter int unsigned BACK_CYCLES  = 10000000
) (
    input logic   clk,
    input logic   rst,
    track_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, TRACK = 3'd1, BOOST = 3'd2, LOST = 3'd3, REVERSE = 3'd4} state_t;
    localparam logic [23:0] DEB = 24'(DEB_CYCLES);
    logic [2:0] sen_m, sen_s, sen_q, filt, last_turn, map, nxt_ctr;
    logic run_m, run_s, obs_m, obs_s;
    logic [23:0] deb_cnt, deb_nxt;
    logic [31:0] str_cnt, tmr;
    state_t st, nxt;
    assign deb_nxt = (sen_s != sen_q) ? 24'd1 : deb_cnt + 24'd1;
    always_comb begin
        map = filt == 3'b011 ? 3'b110 :
              filt == 3'b001 ? 3'b111 :
              filt == 3'b110 ? 3'b101 :
              filt == 3'b100 ? 3'b100 : 3'b000;
        nxt = IDLE;
        case (st)
            IDLE:    nxt = TRACK;
            TRACK:   nxt = filt == 3'b000 ? LOST :
                           (filt == 3'b010 && str_cnt == BOOST_CYCLES - 1) ? BOOST : TRACK;
            BOOST:   nxt = filt == 3'b010 ? BOOST : TRACK;
            LOST:    nxt = filt != 3'b000 ? TRACK : tmr == LOST_CYCLES - 1 ? REVERSE : LOST;
            REVERSE: nxt = (filt != 3'b000 || tmr == BACK_CYCLES - 1) ? TRACK : REVERSE;
            default: nxt = IDLE;
        endcase
        if (!run_s || obs_s) nxt = IDLE;
        nxt_ctr = nxt == TRACK   ? map :
                  nxt == BOOST   ? 3'b010 :
                  nxt == LOST    ? last_turn :
                  nxt == REVERSE ? 3'b011 : 3'b001;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sen_m     <= '0;
            sen_s     <= '0;
            sen_q     <= '0;
            run_m     <= 1'b0;
            run_s     <= 1'b0;
            obs_m     <= 1'b0;
            obs_s     <= 1'b0;
            filt      <= '0;
            deb_cnt   <= '0;
            last_turn <= '0;
            str_cnt   <= '0;
            tmr       <= '0;
            st        <= IDLE;
            bus.ctr   <= 3'b001;
            bus.state <= 3'd0;
        end else begin
            sen_m     <= bus.sensor;
            sen_s     <= sen_m;
            sen_q     <= sen_s;
            run_m     <= bus.run_en;
            run_s     <= run_m;
            obs_m     <= bus.obstacle;
            obs_s     <= obs_m;
            if (sen_s == filt) deb_cnt <= '0;
            else if (deb_nxt == DEB) begin
                filt    <= sen_s;
                deb_cnt <= '0;
            end else deb_cnt <= deb_nxt;
            if (nxt == TRACK && map != 3'b000) last_turn <= map;
            str_cnt   <= (st == TRACK && nxt == TRACK && filt == 3'b010) ? str_cnt + 32'd1 : '0;
            tmr       <= (nxt == st) ? tmr + 32'd1 : '0;
            st        <= nxt;
            bus.ctr   <= nxt_ctr;
            bus.state <= nxt;
        end
    end
endmodule

// File: tb/tb_track_ctrl.sv
// tb_track_ctrl: directed, table-driven and randomized checks of track_ctrl against a timestamp-based reference model
module tb_track_ctrl;
    localparam int DEB = 16, BST = 40, LST = 60, BCK = 80;
    logic clk = 1'b0, rst = 1'b1;
    int checks = 0, errors = 0;
    track_if bus();
    track_ctrl #(.DEB_CYCLES(DEB), .BOOST_CYCLES(BST), .LOST_CYCLES(LST), .BACK_CYCLES(BCK)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct { logic [2:0] sen; logic run; logic obs; int hold; logic [2:0] ctr; logic [2:0] st; } vec_t;
    vec_t tbl [12];
    logic [2:0] steer [8] = '{3'b000, 3'b111, 3'b000, 3'b110, 3'b100, 3'b000, 3'b101, 3'b000};
    logic [2:0] sq [$];
    logic rq [$], oq [$];
    int k = 0, since, enter, str_since, m_st;
    logic prev_cond;
    logic [2:0] m_filt, m_prev_syn, m_last, m_ctr, m_state;
    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask
    task automatic model_step();
        logic [2:0] syn, mp;
        logic rs, os, cond;
        int nst;
        k++;
        if (rst) begin
            sq = {3'd0, 3'd0};
            rq = {1'b0, 1'b0};
            oq = {1'b0, 1'b0};
            m_filt = 0; m_prev_syn = 0; since = k; enter = k; str_since = k;
            prev_cond = 0; m_st = 0; m_last = 0; m_ctr = 3'b001; m_state = 0;
        end else begin
            syn = sq.pop_front(); sq.push_back(bus.sensor);
            rs = rq.pop_front();  rq.push_back(bus.run_en);
            os = oq.pop_front();  oq.push_back(bus.obstacle);
            mp = steer[m_filt];
            cond = (m_st == 1 && m_filt == 3'b010);
            if (cond && !prev_cond) str_since = k;
            prev_cond = cond;
            nst = m_st;
            if (!rs || os) nst = 0;
            else if (m_st == 0) nst = 1;
            else if (m_st == 1) nst = (m_filt == 0) ? 3 : (cond && k - str_since + 1 == BST) ? 2 : 1;
            else if (m_st == 2) nst = (m_filt == 3'b010) ? 2 : 1;
            else if (m_st == 3) nst = (m_filt != 0) ? 1 : (k - enter == LST) ? 4 : 3;
            else nst = (m_filt != 0 || k - enter == BCK) ? 1 : 4;
            if (nst != m_st) enter = k;
            m_st = nst;
            m_state = 3'(nst);
            m_ctr = nst == 0 ? 3'b001 : nst == 1 ? mp : nst == 2 ? 3'b010 : nst == 3 ? m_last : 3'b011;
            if (nst == 1 && mp != 0) m_last = mp;
            if (syn != m_prev_syn) since = k;
            m_prev_syn = syn;
            if (syn != m_filt && k - since + 1 == DEB) m_filt = syn;
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            chk("model_ctr", bus.ctr, m_ctr);
            chk("model_state", bus.state, m_state);
        end
    endtask
    task automatic expect_out(input string name, input logic [2:0] c, input logic [2:0] s);
        chk({name, "_ctr"}, bus.ctr, c);
        chk({name, "_state"}, bus.state, s);
    endtask
    initial begin
        tbl[0]  = '{3'b011, 1'b1, 1'b0, 24, 3'b110, 3'd1};
        tbl[1]  = '{3'b001, 1'b1, 1'b0, 24, 3'b111, 3'd1};
        tbl[2]  = '{3'b110, 1'b1, 1'b0, 24, 3'b101, 3'd1};
        tbl[3]  = '{3'b100, 1'b1, 1'b0, 24, 3'b100, 3'd1};
        tbl[4]  = '{3'b111, 1'b1, 1'b0, 24, 3'b000, 3'd1};
        tbl[5]  = '{3'b101, 1'b1, 1'b0, 24, 3'b000, 3'd1};
        tbl[6]  = '{3'b000, 1'b1, 1'b0, 24, 3'b100, 3'd3};
        tbl[7]  = '{3'b011, 1'b1, 1'b0, 24, 3'b110, 3'd1};
        tbl[8]  = '{3'b011, 1'b0, 1'b0, 4,  3'b001, 3'd0};
        tbl[9]  = '{3'b011, 1'b1, 1'b1, 4,  3'b001, 3'd0};
        tbl[10] = '{3'b011, 1'b1, 1'b0, 4,  3'b110, 3'd1};
        tbl[11] = '{3'b010, 1'b1, 1'b0, 24, 3'b000, 3'd1};
        bus.sensor = 3'b000; bus.run_en = 1'b0; bus.obstacle = 1'b0;
        cyc(3);
        expect_out("reset", 3'b001, 3'd0);
        rst = 1'b0;
        bus.run_en = 1'b1; bus.sensor = 3'b010;
        cyc(DEB + 3);
        expect_out("track_straight", 3'b000, 3'd1);
        cyc(BST - 1);
        chk("pre_boost_state", bus.state, 3'd1);
        cyc(1);
        expect_out("boost", 3'b010, 3'd2);
        bus.obstacle = 1'b1;
        cyc(2);
        chk("obs_edge2_state", bus.state, 3'd2);
        cyc(1);
        expect_out("obs_stop", 3'b001, 3'd0);
        cyc(20);
        expect_out("obs_hold", 3'b001, 3'd0);
        bus.obstacle = 1'b0;
        cyc(3);
        expect_out("obs_release", 3'b000, 3'd1);
        bus.sensor = 3'b011;
        cyc(DEB + 3);
        expect_out("right_half", 3'b110, 3'd1);
        bus.sensor = 3'b000;
        cyc(10);
        bus.sensor = 3'b011;
        expect_out("glitch_mid", 3'b110, 3'd1);
        cyc(30);
        expect_out("glitch_after", 3'b110, 3'd1);
        bus.sensor = 3'b001;
        cyc(DEB + 3);
        expect_out("right_sharp", 3'b111, 3'd1);
        bus.sensor = 3'b000;
        cyc(DEB + 3);
        expect_out("lost", 3'b111, 3'd3);
        cyc(LST - 1);
        chk("lost_hold_state", bus.state, 3'd3);
        cyc(1);
        expect_out("reverse", 3'b011, 3'd4);
        cyc(BCK - 1);
        chk("reverse_hold_state", bus.state, 3'd4);
        cyc(1);
        expect_out("reverse_done", 3'b000, 3'd1);
        cyc(1);
        expect_out("relost", 3'b111, 3'd3);
        cyc(LST);
        expect_out("reverse2", 3'b011, 3'd4);
        bus.sensor = 3'b010;
        cyc(DEB + 2);
        chk("abort_pending_state", bus.state, 3'd4);
        cyc(1);
        expect_out("reverse_abort", 3'b000, 3'd1);
        bus.sensor = 3'b000;
        cyc(DEB + 3 + LST);
        expect_out("reverse3", 3'b011, 3'd4);
        rst = 1'b1;
        cyc(1);
        expect_out("rst_in_reverse", 3'b001, 3'd0);
        rst = 1'b0;
        cyc(3);
        expect_out("post_rst_track", 3'b000, 3'd1);
        cyc(1);
        expect_out("post_rst_lost", 3'b000, 3'd3);
        for (int i = 0; i < 12; i++) begin
            bus.sensor = tbl[i].sen; bus.run_en = tbl[i].run; bus.obstacle = tbl[i].obs;
            cyc(tbl[i].hold);
            expect_out($sformatf("tbl%0d", i), tbl[i].ctr, tbl[i].st);
        end
        for (int i = 0; i < 60; i++) begin
            logic [2:0] s;
            s = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom_range(0, 7));
            bus.sensor   = s;
            bus.run_en   = ($urandom_range(0, 19) != 0);
            bus.obstacle = ($urandom_range(0, 24) == 0);
            rst          = ($urandom_range(0, 39) == 0);
            if (rst) begin
                cyc(1);
                rst = 1'b0;
            end
            cyc(s == 3'b000 ? int'($urandom_range(1, 220)) : int'($urandom_range(1, 90)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/track_ctrl.md
# track_ctrl

Line-tracking decision controller that turns three IR reflectance sensors, a run switch and an obstacle flag into the 3-bit drive command `ctr` consumed directly by the PWM motor stage. It synchronises and debounces the sensor inputs and steers from the filtered pattern. A state machine handles idle/stop, a straight-line speed boost, line-lost recovery and a timed reverse.

## Interface
- `DEB_CYCLES`, 50000: consecutive cycles a new synchronised sensor vector must hold before it is accepted (1 ms at 50 MHz); range 1..2^24-1.
- `BOOST_CYCLES`, 2500000: consecutive cycles of filtered `010` in TRACK before entering BOOST.
- `LOST_CYCLES`, 5000000: cycles spent in LOST before REVERSE.
- `BACK_CYCLES`, 10000000: cycles spent in REVERSE.
- `clk` input 1: single system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sensor` input 3: [2]=left, [1]=centre, [0]=right; 1 = line under sensor; asynchronous.
- `run_en` input 1: run switch, asynchronous; 1 = drive permitted.
- `obstacle` input 1: asynchronous; 1 = obstacle ahead, forces stop.
- `ctr` output 3: drive command to the PWM stage (registered).
- `state` output 3: current FSM state for debug (registered).

## Operation
- Command codes: 000 straight, 010 boost straight, 110 right half, 111 right sharp, 101 left half, 100 left sharp, 011 reverse, 001 stop.
- Synchronisers: `sensor`, `run_en` and `obstacle` each pass through two flops; reset value 0.
- Debounce: `filt[2:0]` (reset 000). A 24-bit counter clears when synced vector equals `filt` or changes from the previous cycle, and otherwise increments. When the count reaches DEB_CYCLES, `filt` loads the synced vector and the counter clears. Bits are debounced together as one vector.
- Steering map from `filt`: 010/111/101 -> 000; 011 -> 110; 001 -> 111; 110 -> 101; 100 -> 100; 000 = no line.
- `last_turn` (reset 000) loads the map result whenever TRACK emits a turn code (110/111/101/100).
- States and encodings: IDLE=0, TRACK=1, BOOST=2, LOST=3, REVERSE=4. Any unused encoding returns to IDLE.
- Global priority: synced `run_en`=0 or synced `obstacle`=1 forces IDLE from every state, over all other transitions.
- IDLE: ctr=001. Goes to TRACK when run permitted.
- TRACK: ctr = map(`filt`). If `filt`=000, go to LOST. A straight counter counts consecutive cycles of `filt`=010 and clears on any other pattern or when leaving TRACK. When it reaches BOOST_CYCLES, go to BOOST.
- BOOST: ctr=010 while `filt`=010. Any other pattern returns to TRACK.
- LOST: ctr=`last_turn`. Any nonzero `filt` returns to TRACK. A timer counts from 0 on entry; at LOST_CYCLES, go to REVERSE.
- REVERSE: ctr=011. A timer counts from 0 on entry; at BACK_CYCLES, go to TRACK. Any nonzero `filt` aborts early to TRACK. If `filt` is still 000 on re-entering TRACK, the FSM goes back to LOST with a fresh timer.
- `ctr` and `state` are registered from the next-state logic, so they update on the same edge as the state register.

## Timing
- Reset: `ctr`=001, `state`=0, `filt`=000, `last_turn`=000, all counters 0, all sync flops 0. Reset asserted mid-operation takes effect at the next edge, in any state.
- Sensor latency: `sensor` changes and then holds. Synced value appears after 2 edges. `filt` updates at edge 2+DEB_CYCLES. `state`/`ctr` update at edge 3+DEB_CYCLES.
- Any sensor glitch shorter than DEB_CYCLES cycles leaves `filt` unchanged.
- Stop latency: `obstacle` rise or `run_en` fall produces ctr=001 at edge 3 after the input change, with no debounce.
- Timer exits: LOST entered at edge N exits to REVERSE at edge N+LOST_CYCLES. REVERSE behaves the same way with BACK_CYCLES.
- Simultaneous events: stop condition beats line reappearance and timer expiry. Line reappearance beats timer expiry.

## Test plan
- Reset, then run_en=1, sensor=010 held -> ctr 001 after reset; ctr 000 by edge DEB_CYCLES+3; ctr 010 after a further BOOST_CYCLES edges.
- Sensor 011 held, then a 10-cycle 000 glitch -> ctr=110, state=1 throughout; glitch ignored (small DEB_CYCLES, e.g. 16).
- Sensor 001 then 000 held -> ctr 111, then LOST with ctr=111; after LOST_CYCLES ctr=011; after BACK_CYCLES back to LOST (state 3).
- In REVERSE, sensor=010 -> state 1, ctr=000 at DEB_CYCLES+3 edges after the sensor change.
- In BOOST, obstacle=1 for one long pulse -> ctr=001, state=0 at edge 3. Obstacle released -> TRACK.
- rst asserted in REVERSE for 1 cycle -> next edge: ctr=001, state=0; `last_turn` cleared, so a following LOST emits 000.
